pc_sequencer: RTL

- Program-counter and fetch-sequencing stage of the Simple Computer.
- Sits directly upstream of the combinational instruction ROM: its `pc` output drives the ROM address, and the ROM returns the instruction in the same cycle.
- Takes next-address controls (branch, jump, stall, halt) from the decoder/datapath.
- Runs an IDLE/RUN/HALT sequencer and counts retired instructions.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer (IDLE/RUN/HALT) with a saturating retired-instruction counter.
// Optional PC_WRAP_HALT_EN: halt with a sticky wrap_err instead of wrapping on a sequential increment past the top address.
module pc_sequencer #(
    parameter int ADDR_WIDTH = 6,
    parameter int OFFS_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  stall,
    input  logic                  halt_req,
    input  logic                  branch_taken,
    input  logic [OFFS_WIDTH-1:0] branch_offset,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  instr_count,
`ifdef PC_WRAP_HALT_EN
    output logic                  wrap_err,
`endif
    // Sequencer state for checkers: 0 = IDLE, 1 = RUN, 2 = HALT.
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  offs_ext;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic [CNT_WIDTH-1:0]   cnt_next;

    assign state_dbg = state;

    generate
        if (ADDR_WIDTH > OFFS_WIDTH) begin : g_sext
            assign offs_ext = {{(ADDR_WIDTH-OFFS_WIDTH){branch_offset[OFFS_WIDTH-1]}}, branch_offset};
        end else begin : g_trunc
            assign offs_ext = branch_offset[ADDR_WIDTH-1:0];
        end
    endgenerate

    // Offset is relative to the following instruction; the sum wraps modulo 2^ADDR_WIDTH.
    assign branch_target = pc + ADDR_WIDTH'(1) + offs_ext;
    assign cnt_next      = (instr_count == '1) ? instr_count : instr_count + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            running     <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
`ifdef PC_WRAP_HALT_EN
            wrap_err    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        pc      <= '0;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        state   <= S_HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (jump_en) begin
                        pc          <= jump_addr;
                        instr_count <= cnt_next;
                    end else if (branch_taken) begin
                        pc          <= branch_target;
                        instr_count <= cnt_next;
                    end else begin
`ifdef PC_WRAP_HALT_EN
                        if (pc == '1) begin
                            state    <= S_HALT;
                            running  <= 1'b0;
                            halted   <= 1'b1;
                            wrap_err <= 1'b1;
                        end else
`endif
                        begin
                            pc          <= pc + ADDR_WIDTH'(1);
                            instr_count <= cnt_next;
                        end
                    end
                end
                S_HALT: begin
                    // Restart from address 0 with a fresh count.
                    if (run) begin
                        state       <= S_RUN;
                        running     <= 1'b1;
                        halted      <= 1'b0;
                        pc          <= '0;
                        instr_count <= '0;
`ifdef PC_WRAP_HALT_EN
                        wrap_err    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
